// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_t : serialiser states (PARITY is only reachable when the
//                parity option is compiled in)
//   baud_div   : clocks per bit, rounded to nearest
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous ready/valid FIFO with asynchronous active-high reset.
// Ports:
//   clk, reset             clock, async active-high reset
//   push_data/valid/ready  write handshake; push_ready = count < DEPTH
//   pop_data/valid/ready   read handshake; pop_data shows the head word
//   count                  words currently stored
// A full FIFO refuses a push even when a pop happens in the same cycle,
// so push_ready depends on count alone.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     push_valid,
  output logic                     push_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  assign push_ready = (count < FULL);
  assign pop_valid  = (count != '0);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid & push_ready;
  assign pop        = pop_valid & pop_ready;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: an N-deep FIFO feeding a serialiser.
// Optional feature macro: UART_PARITY_EN (adds a parity bit after the
// data bits; parity = ^data ^ PARITY_ODD). Default build has no parity.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   in_data     word to transmit
//   in_valid    producer holds in_data valid
//   in_ready    FIFO can accept (count < FIFO_DEPTH)
//   txd         serial line, idle high, registered
//   busy        serialiser not idle
//   fifo_count  words currently queued
// txd is registered from the current state, so the line trails the
// state register by one clock; frames stay exactly DIV clocks per bit and
// back-to-back frames have no gap because the next word is popped on the
// same edge that leaves the final stop bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: clocks per bit must be at least 2");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_dw_chk
    $error("uart_tx_fifo: DATA_W must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  tx_state_t         state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_valid;
  logic              baud_zero;
  logic              frame_end;
  logic              pop_req;
  logic              pop;
`ifdef UART_PARITY_EN
  logic              par_bit;
`endif

  uart_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_data  (in_data),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .pop_data   (fifo_data),
    .pop_valid  (fifo_valid),
    .pop_ready  (pop_req),
    .count      (fifo_count)
  );

  assign baud_zero = (baud_cnt == '0);
  assign frame_end = (state == STOP) && baud_zero && (bit_cnt == LAST_STOP);
  // The serialiser takes a word when idle or on the last clock of a frame.
  assign pop_req   = (state == IDLE) || frame_end;
  assign pop       = pop_req & fifo_valid;

  // Control: state, baud counter, bit counter and line output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      baud_cnt <= baud_zero ? DIV_M1 : baud_cnt - 1'b1;
      case (state)
        IDLE: begin
          txd      <= 1'b1;
          baud_cnt <= DIV_M1;
          bit_cnt  <= '0;
          if (fifo_valid) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          txd <= 1'b0;
          if (baud_zero) state <= DATA;
        end
        DATA: begin
          txd <= shreg[0];
          if (baud_zero) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          txd <= par_bit;
          if (baud_zero) state <= STOP;
        end
`endif
        STOP: begin
          txd <= 1'b1;
          if (baud_zero) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              if (fifo_valid) begin
                state <= START;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: shift register loads on pop and shifts at each data-bit end.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= fifo_data;
    end else if (state == DATA && baud_zero) begin
      shreg <= shreg >> 1;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (pop) par_bit <= (^fifo_data) ^ (PARITY_ODD != 0);
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (DIV=4, DATA_W=8, FIFO_DEPTH=4, one stop bit).
// A frame-level reference model (word queue + expected line waveform)
// predicts txd, busy, fifo_count and in_ready every clock; directed
// sequences add latency, framing, full-FIFO, back-to-back and reset checks,
// followed by randomized traffic.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ   = 400;
  localparam int BAUD       = 100;
  localparam int DIV        = 4;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int F     = (1 + DATA_W + PAR_BITS + STOP_BITS) * DIV;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              txd;
  logic              busy;
  logic [CNT_W-1:0]  fifo_count;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .STOP_BITS  (STOP_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] q[$];      // words waiting in the FIFO
  bit                line_q[$]; // per-clock txd values still to appear
  int                left = 0;  // clocks until the current frame ends
  bit                exp_txd = 1'b1;
  bit                acc_last = 1'b0;
  int                cyc = 0;
  int                last_acc_cyc = 0;
  bit                m_push, m_pop;
  int                m_pre;
  logic [DATA_W-1:0] m_word;

  function automatic void append_frame(input logic [DATA_W-1:0] w);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(w[i]);
`ifdef UART_PARITY_EN
    bits.push_back((^w) ^ (PARITY_ODD != 0));
`endif
    for (int i = 0; i < STOP_BITS; i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int k = 0; k < DIV; k++) line_q.push_back(bits[i]);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (clk) cyc++;
    if (reset) begin
      q.delete();
      line_q.delete();
      left     = 0;
      exp_txd  = 1'b1;
      acc_last = 1'b0;
    end else begin
      m_pre   = q.size();
      m_push  = in_valid && (m_pre < FIFO_DEPTH);
      m_pop   = (m_pre > 0) && (left <= 1);
      exp_txd = (line_q.size() > 0) ? line_q.pop_front() : 1'b1;
      if (left > 0) left--;
      if (m_pop) begin
        m_word = q.pop_front();
        append_frame(m_word);
        left = F;
      end
      if (m_push) begin
        q.push_back(in_data);
        last_acc_cyc = cyc;
      end
      acc_last = m_push;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("txd", txd, exp_txd);
      check_eq("busy", busy, left > 0);
      check_eq("fifo_count", fifo_count, q.size());
      check_eq("in_ready", in_ready, q.size() < FIFO_DEPTH);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [DATA_W-1:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!acc_last && n < 200);
    if (!acc_last) check_eq("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_txd(input logic lvl, input int limit, output int n);
    n = 0;
    while (txd !== lvl && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (txd !== lvl) check_eq("txd_wait_timeout", txd, lvl);
  endtask

  // Entered just after the start-bit falling edge; samples mid-bit.
  task automatic rx_frame(output logic [DATA_W-1:0] w, output logic par, output logic ok);
    ok = 1'b1;
    par = 1'b0;
    repeat (DIV / 2) @(posedge clk);
    #1;
    if (txd !== 1'b0) ok = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      repeat (DIV) @(posedge clk);
      #1;
      w[i] = txd;
    end
`ifdef UART_PARITY_EN
    repeat (DIV) @(posedge clk);
    #1;
    par = txd;
`endif
    repeat (DIV) @(posedge clk);
    #1;
    if (txd !== 1'b1) ok = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((left > 0 || q.size() > 0) && n < 2000) begin
      @(negedge clk); n++;
    end
    check_eq("drain_timeout", (left > 0 || q.size() > 0), 0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, t1, t2, n_low, target;
    logic [DATA_W-1:0] w;
    logic par, ok;

    // Power-on reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // 1: asynchronous reset mid-cycle while a start bit is on the line
    send(8'h5A);
    a0 = last_acc_cyc;
    send(8'h11);
    while (cyc < a0 + 3) begin @(posedge clk); #1; end
    check_eq("pre_reset_txd", txd, 0);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_txd", txd, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_count", fifo_count, 0);
    check_eq("rst_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 2: single frame 0xA5, latency and bit order
    send(8'hA5);
    wait_txd(1'b0, 10, n);
    check_eq("a5_latency", n, 2);
    rx_frame(w, par, ok);
    check_eq("a5_word", w, 8'hA5);
    check_eq("a5_framing", ok, 1);
    n = 0;
    while (busy !== 1'b0 && n < 10) begin @(posedge clk); #1; n++; end
    check_eq("a5_busy_clear", busy, 0);
    @(negedge clk);
    drain();

    // 3: fill the FIFO behind an active frame
    send(8'h10);
    a0 = last_acc_cyc;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    check_eq("full_count", fifo_count, 4);
    check_eq("full_ready", in_ready, 0);
    send(8'h2F);
    check_eq("fifth_acc_cyc", last_acc_cyc, a0 + 2 + F);
    check_eq("fifth_count", fifo_count, 4);
    drain();

    // 4: back-to-back frames 0x00, 0xFF with no idle clock between them
    send(8'h00);
    send(8'hFF);
    wait_txd(1'b0, 10, n);
    t1 = cyc;
    wait_txd(1'b1, 2 * F, n);
    wait_txd(1'b0, 2 * F, n);
    t2 = cyc;
    check_eq("b2b_start_spacing", t2 - t1, F);
    @(negedge clk);
    drain();

    // 5: reset during bit 3 of 0x3C with two words queued
    send(8'h3C);
    a0 = last_acc_cyc;
    send(8'h41);
    send(8'h42);
    check_eq("queued_two", fifo_count, 2);
    target = a0 + 2 + DIV * 4 + 1;
    while (cyc < target) begin @(posedge clk); #1; end
    check_eq("bit3_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_txd", txd, 1);
    check_eq("mid_rst_count", fifo_count, 0);
    check_eq("mid_rst_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_low = 0;
    for (int i = 0; i < 3 * F; i++) begin
      @(posedge clk); #1;
      if (txd !== 1'b1 || busy !== 1'b0) n_low++;
    end
    check_eq("post_reset_quiet", n_low, 0);
    @(negedge clk);

    // 6: 0x07 -> parity bit (when enabled) then stop
    send(8'h07);
    wait_txd(1'b0, 10, n);
    rx_frame(w, par, ok);
    check_eq("w07_word", w, 8'h07);
    check_eq("w07_framing", ok, 1);
`ifdef UART_PARITY_EN
    check_eq("w07_parity", par, 1);
`endif
    @(negedge clk);
    drain();

    // Randomized traffic with random gaps
    for (int i = 0; i < 40; i++) begin
      send(DATA_W'($urandom));
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(0, 60)) @(negedge clk);
      else repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
